mem_wb_stage: RTL and testbench

MEM stage plus MEM/WB pipeline register of the five-stage MIPS pipeline, sitting directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs, resolves the branch decision and performs word accesses on a local data memory.
- Registers everything the write-back stage needs on the falling clock edge, matching the other pipeline registers.
- Adds asynchronous reset and a stall hold, which the write-back path requires.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/data_mem.sv | 24 ++
 rtl/mem_wb_stage.sv | 94 +++++++++
 tb/tb_mem_wb_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath widths, data memory sizing defaults
// and the MEM/WB register payload.
package cpu_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_W      = 5;
  localparam int DEPTH_DEF  = 1024;
  localparam int ADDR_W_DEF = 10;

  typedef struct packed {
    logic [WORD_W-1:0] mem_data;
    logic [WORD_W-1:0] alu_out;
    logic [REG_W-1:0]  rw;
    logic              memtoreg;
    logic              regwr;
  } mem_wb_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous rising-edge write, asynchronous read.
module data_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch; clearing it would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and falling-edge MEM/WB register. Optional misaligned-access trap
// is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] NewPC,
  input  logic              Zero,
  input  logic              Overflow,
  input  logic [WORD_W-1:0] ALUout,
  input  logic [REG_W-1:0]  Rw,
  input  logic              MemWr,
  input  logic              Branch,
  input  logic              MemtoReg,
  input  logic              RegWr,
  input  logic [WORD_W-1:0] busB,
  input  logic              stall,
  output logic              PCSrc,
  output logic [WORD_W-1:0] BranchTarget,
  output logic [WORD_W-1:0] MemData_out,
  output logic [WORD_W-1:0] ALUout_out,
  output logic [REG_W-1:0]  Rw_out,
  output logic              MemtoReg_out,
  output logic              RegWr_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              Misalign_out
`endif
);

  logic [WORD_W-1:0] rdata;
  logic              wr_en;
  logic              regwr_eff;
  mem_wb_t           wb_d, wb_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (MemWr | MemtoReg) & (ALUout[1:0] != 2'b00);
`else
  localparam logic misaligned = 1'b0;
`endif

  assign PCSrc        = Branch & Zero;
  assign BranchTarget = NewPC;

  // rst gates the write so a reset landing mid-cycle cannot commit a store.
  assign wr_en     = MemWr & ~Overflow & ~stall & ~rst & ~misaligned;
  assign regwr_eff = RegWr & ~Overflow & ~(misaligned & MemtoReg);

  data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .we_i   (wr_en),
    .addr_i (ALUout[ADDR_W+1:2]),
    .wdata_i(busB),
    .rdata_o(rdata)
  );

  always_comb begin
    wb_d = wb_q;
    if (!stall) begin
      wb_d.mem_data = rdata;
      wb_d.alu_out  = ALUout;
      wb_d.rw       = Rw;
      wb_d.memtoreg = MemtoReg;
      wb_d.regwr    = regwr_eff;
    end
  end

  // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  assign MemData_out  = wb_q.mem_data;
  assign ALUout_out   = wb_q.alu_out;
  assign Rw_out       = wb_q.rw;
  assign MemtoReg_out = wb_q.memtoreg;
  assign RegWr_out    = wb_q.regwr;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(negedge clk or posedge rst) begin
    if (rst)        misalign_q <= 1'b0;
    else if (!stall) misalign_q <= misaligned;
  end
  assign Misalign_out = misalign_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: array-based reference model compared
// every cycle, plus directed literal checks. Honors MEM_MISALIGN_TRAP_EN.
module tb_mem_wb_stage;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] NewPC, ALUout, busB;
  logic        Zero, Overflow, MemWr, Branch, MemtoReg, RegWr, stall;
  logic [4:0]  Rw;
  logic        PCSrc;
  logic [31:0] BranchTarget, MemData_out, ALUout_out;
  logic [4:0]  Rw_out;
  logic        MemtoReg_out, RegWr_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        Misalign_out;
`endif

  int tests = 0;
  int fails = 0;

  mem_wb_stage #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .NewPC(NewPC), .Zero(Zero), .Overflow(Overflow),
    .ALUout(ALUout), .Rw(Rw), .MemWr(MemWr), .Branch(Branch),
    .MemtoReg(MemtoReg), .RegWr(RegWr), .busB(busB), .stall(stall),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .MemData_out(MemData_out),
    .ALUout_out(ALUout_out), .Rw_out(Rw_out), .MemtoReg_out(MemtoReg_out),
    .RegWr_out(RegWr_out)
`ifdef MEM_MISALIGN_TRAP_EN
    , .Misalign_out(Misalign_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] e_data, e_alu;
  logic [4:0]  e_rw;
  logic        e_m2r, e_rwr, e_mis;
  bit          e_known;

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic is_mis();
`ifdef MEM_MISALIGN_TRAP_EN
    return (MemWr || MemtoReg) && (ALUout % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (MemWr && !Overflow && !stall && !rst && !is_mis()) begin
      m_mem[word_of(ALUout)]   = busB;
      m_known[word_of(ALUout)] = 1'b1;
    end
  end

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      e_data = 0; e_alu = 0; e_rw = 0; e_m2r = 0; e_rwr = 0; e_mis = 0; e_known = 1'b1;
    end else if (!stall) begin
      e_data  = m_mem[word_of(ALUout)];
      e_known = m_known[word_of(ALUout)];
      e_alu   = ALUout;
      e_rw    = Rw;
      e_m2r   = MemtoReg;
      e_mis   = is_mis();
      e_rwr   = RegWr && !Overflow && !(e_mis && MemtoReg);
    end
  end

  always @(posedge clk) begin
    #1;
    check("PCSrc", {31'b0, PCSrc}, {31'b0, Branch & Zero});
    check("BranchTarget", BranchTarget, NewPC);
    check("ALUout_out", ALUout_out, e_alu);
    check("Rw_out", {27'b0, Rw_out}, {27'b0, e_rw});
    check("MemtoReg_out", {31'b0, MemtoReg_out}, {31'b0, e_m2r});
    check("RegWr_out", {31'b0, RegWr_out}, {31'b0, e_rwr});
    if (e_known) check("MemData_out", MemData_out, e_data);
`ifdef MEM_MISALIGN_TRAP_EN
    check("Misalign_out", {31'b0, Misalign_out}, {31'b0, e_mis});
`endif
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0] newpc, alu, busb;
    logic        zero, ovf, memwr, branch, m2r, regwr, stall;
    logic [4:0]  rw;
  } instr_t;

  function automatic instr_t nop();
    instr_t i;
    i.newpc = 0; i.alu = 0; i.busb = 0; i.zero = 0; i.ovf = 0; i.memwr = 0;
    i.branch = 0; i.m2r = 0; i.regwr = 0; i.stall = 0; i.rw = 0;
    return i;
  endfunction

  function automatic instr_t st(input logic [31:0] a, input logic [31:0] d);
    instr_t i = nop();
    i.memwr = 1; i.alu = a; i.busb = d;
    return i;
  endfunction

  function automatic instr_t ld(input logic [31:0] a, input logic [4:0] r);
    instr_t i = nop();
    i.m2r = 1; i.regwr = 1; i.alu = a; i.rw = r;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    NewPC = i.newpc; ALUout = i.alu; busB = i.busb; Zero = i.zero;
    Overflow = i.ovf; MemWr = i.memwr; Branch = i.branch; MemtoReg = i.m2r;
    RegWr = i.regwr; stall = i.stall; Rw = i.rw;
  endtask

  // Present one instruction for a full MEM cycle; returns just after its capture edge.
  task automatic apply(input instr_t i);
    drive(i);
    @(negedge clk); #1;
  endtask

  initial begin
    instr_t i;
    rst = 1'b1;
    drive(nop());
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Preload, then reset hold with arbitrary traffic
    apply(st(32'h14, 32'h5555_5555));
    apply(st(32'h1C, 32'h7777_7777));
    apply(st(32'h24, 32'h9999_9999));
    apply(ld(32'h1C, 5'd3));
    check("preload_load", MemData_out, 32'h7777_7777);
    rst = 1'b1;
    #1 check("rst_async_clear", {ALUout_out[15:0], 11'b0, Rw_out}, 32'h0);
    i = st(32'h14, 32'hA5A5_A5A5); i.regwr = 1; i.m2r = 1; i.rw = 5'd17;
    apply(i);
    apply(i);
    check("rst_hold_alu", ALUout_out, 32'h0);
    check("rst_hold_regwr", {31'b0, RegWr_out}, 32'h0);
    rst = 1'b0;
    apply(ld(32'h14, 5'd1));
    check("rst_mem_unchanged", MemData_out, 32'h5555_5555);

    // Store then back-to-back load
    apply(st(32'h14, 32'hDEAD_BEEF));
    apply(ld(32'h14, 5'd8));
    check("ld_data", MemData_out, 32'hDEAD_BEEF);
    check("ld_rw", {27'b0, Rw_out}, 32'd8);
    check("ld_regwr", {31'b0, RegWr_out}, 32'd1);

    // Branch resolution
    i = nop(); i.branch = 1; i.zero = 1; i.newpc = 32'h40;
    apply(i);
    check("br_taken", {31'b0, PCSrc}, 32'd1);
    check("br_target", BranchTarget, 32'h40);
    Zero = 1'b0;
    #1 check("br_not_taken", {31'b0, PCSrc}, 32'd0);

    // Overflow suppression
    i = nop(); i.regwr = 1; i.ovf = 1; i.alu = 32'h7FFF_FFFF; i.rw = 5'd4;
    apply(i);
    check("ovf_regwr", {31'b0, RegWr_out}, 32'd0);
    check("ovf_alu", ALUout_out, 32'h7FFF_FFFF);
    i = st(32'h14, 32'h0000_0BAD); i.ovf = 1;
    apply(i);
    apply(ld(32'h14, 5'd2));
    check("ovf_store_blocked", MemData_out, 32'hDEAD_BEEF);

    // Stall hold
    apply(ld(32'h14, 5'd9));
    i = st(32'h20, 32'hB0B0_B0B0); i.rw = 5'd12; i.stall = 1;
    apply(i);
    check("stall_hold_alu", ALUout_out, 32'h14);
    check("stall_hold_rw", {27'b0, Rw_out}, 32'd9);
    i.stall = 0;
    apply(i);
    check("stall_release_alu", ALUout_out, 32'h20);
    check("stall_release_rw", {27'b0, Rw_out}, 32'd12);
    i = st(32'h24, 32'h1234_5678); i.stall = 1;
    apply(i);
    apply(ld(32'h24, 5'd5));
    check("stall_store_blocked", MemData_out, 32'h9999_9999);

    // Reset mid-cycle blocks an in-flight store
    apply(ld(32'h20, 5'd6));
    check("ld_after_stall", MemData_out, 32'hB0B0_B0B0);
    i = st(32'h1C, 32'hBBBB_BBBB); i.rw = 5'd3;
    drive(i);
    #2 rst = 1'b1;
    #1 check("rst_mid_clear", ALUout_out, 32'h0);
    #4 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_release_capture", ALUout_out, 32'h1C);
    apply(ld(32'h1C, 5'd7));
    check("rst_store_blocked", MemData_out, 32'h7777_7777);

    // Address wrap
    apply(ld(32'h1014, 5'd10));
    check("wrap_alias", MemData_out, 32'hDEAD_BEEF);
    apply(st(32'h2018, 32'h6666_6666));
    apply(ld(32'h18, 5'd11));
    check("wrap_store", MemData_out, 32'h6666_6666);

    // Misaligned access
    apply(st(32'h16, 32'h1616_1616));
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_flag", {31'b0, Misalign_out}, 32'd1);
    apply(ld(32'h15, 5'd13));
    check("mis_load_regwr", {31'b0, RegWr_out}, 32'd0);
    apply(ld(32'h14, 5'd13));
    check("mis_store_blocked", MemData_out, 32'hDEAD_BEEF);
`else
    apply(ld(32'h17, 5'd13));
    check("trunc_store", MemData_out, 32'h1616_1616);
    check("trunc_load_regwr", {31'b0, RegWr_out}, 32'd1);
`endif

    apply(nop());
    apply(nop());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
